// File: rtl/ddr4_ctrl_pkg.sv
// Shared DDR4 controller types: request opcodes, address field layout and
// the decoded low-address struct used by the request queue.
package ddr4_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  localparam int BYTE_LSB  = 0;
  localparam int BYTE_W    = 3;
  localparam int BURST_LSB = 3;
  localparam int BURST_W   = 3;
  localparam int BG_LSB    = 6;
  localparam int BG_W      = 2;
  localparam int BANK_LSB  = 8;
  localparam int BANK_W    = 2;
  localparam int COL_LSB   = 10;
  localparam int COL_W     = 8;
  localparam int ROW_LSB   = 18;

  // Fixed-width portion of a decoded address; the row width depends on the
  // CPU address width and is carried separately by the queue.
  typedef struct packed {
    logic [COL_W-1:0]   col;
    logic [BANK_W-1:0]  bank;
    logic [BG_W-1:0]    bank_group;
    logic [BURST_W-1:0] burst_order;
    logic [BYTE_W-1:0]  byte_index;
  } req_fields_t;

  function automatic req_fields_t decode_low(input logic [ROW_LSB-1:0] a);
    req_fields_t d;
    d.byte_index  = a[BYTE_LSB  +: BYTE_W];
    d.burst_order = a[BURST_LSB +: BURST_W];
    d.bank_group  = a[BG_LSB    +: BG_W];
    d.bank        = a[BANK_LSB  +: BANK_W];
    d.col         = a[COL_LSB   +: COL_W];
    return d;
  endfunction

endpackage

// File: rtl/mem_req_ring.sv
// Circular buffer with wrap-around head/tail pointers and an occupancy count.
// Pushes while full and pops while empty are ignored, so the count can never
// overflow or underflow.
module mem_req_ring #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[head];

  // Storage is not reset; stale slots are never visible because the
  // pointers and count are.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop moves both
  // pointers and leaves the count alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= next_ptr(tail);
      if (pop_ok)  head <= next_ptr(head);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_request_queue.sv
// Memory request queue: decodes CPU addresses into DDR4 fields at push time,
// holds each request for MIN_AGE cycles, then presents it at the head either
// for a handshake or for automatic retirement.
module mem_request_queue
  import ddr4_ctrl_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int ADDR_W      = 36,
  parameter  int TIME_W      = 64,
  parameter  int MIN_AGE     = 100,
  parameter  int AUTO_RETIRE = 1,
  localparam int ROW_W       = ADDR_W - ROW_LSB,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TIME_W-1:0] in_time,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] out_time,
  output logic [1:0]        out_op,
  output logic [ROW_W-1:0]  out_row,
  output logic [7:0]        out_col,
  output logic [1:0]        out_bank,
  output logic [1:0]        out_bank_group,
  output logic [2:0]        out_burst_order,
  output logic [2:0]        out_byte_index,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err_illegal_op
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = (MIN_AGE > 0) ? $clog2(MIN_AGE + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_AGE);

  typedef struct packed {
    logic [TIME_W-1:0] time_stamp;
    logic [1:0]        op;
    logic [ROW_W-1:0]  row;
    req_fields_t       fields;
  } entry_t;

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [AGE_W-1:0] age [DEPTH];
  logic             accept;
  logic             push;
  logic             pop;

  // in_ready looks only at registered occupancy; a pop in the same cycle
  // does not open a slot until the following cycle.
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_op != OP_ILLEGAL);
  assign out_valid = !empty && (age[head] == AGE_MAX);
  assign pop       = out_valid && ((AUTO_RETIRE != 0) || out_ready);

  assign wr_entry.time_stamp = in_time;
  assign wr_entry.op         = in_op;
  assign wr_entry.row        = in_addr[ADDR_W-1:ROW_LSB];
  assign wr_entry.fields     = decode_low(in_addr[ROW_LSB-1:0]);

  mem_req_ring #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .head    (head),
    .tail    (tail),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Head fields read as zero while nothing is queued.
  assign out_time        = empty ? '0 : rd_entry.time_stamp;
  assign out_op          = empty ? '0 : rd_entry.op;
  assign out_row         = empty ? '0 : rd_entry.row;
  assign out_col         = empty ? '0 : rd_entry.fields.col;
  assign out_bank        = empty ? '0 : rd_entry.fields.bank;
  assign out_bank_group  = empty ? '0 : rd_entry.fields.bank_group;
  assign out_burst_order = empty ? '0 : rd_entry.fields.burst_order;
  assign out_byte_index  = empty ? '0 : rd_entry.fields.byte_index;

  // Per-slot age: cleared when the slot is written, then counts up and
  // saturates at MIN_AGE; unoccupied slots age harmlessly.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)                                   age[i] <= '0;
      else if (push && (tail == PTR_W'(i)))        age[i] <= '0;
      else if (age[i] != AGE_MAX)                  age[i] <= age[i] + 1'b1;
    end
  end

  // Sticky flag for a consumed-but-dropped illegal opcode.
  always_ff @(posedge clock) begin
    if (reset)                                     err_illegal_op <= 1'b0;
    else if (accept && (in_op == OP_ILLEGAL))      err_illegal_op <= 1'b1;
  end

endmodule

// File: doc/mem_request_queue.md
MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-002 DEPTH, 16, number of entries (>=2, any integer).
REQ-003 ADDR_W, 36, CPU address width (>=19).
REQ-004 TIME_W, 64, request timestamp width.
REQ-005 MIN_AGE, 100, cycles an entry must reside before it becomes eligible (0 allowed).
REQ-006 AUTO_RETIRE, 1, 1 = eligible head pops without handshake; 0 = pop requires out_ready.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 in_valid  in  1  request offered.
REQ-010 in_ready  out  1  queue can accept this cycle.
REQ-011 in_time  in  TIME_W  request timestamp.
REQ-012 in_op  in  2  0 READ, 1 WRITE, 2 INSTRUCTION_FETCH, 3 illegal.
REQ-013 in_addr  in  ADDR_W  CPU address.
REQ-014 out_valid  out  1  head present and eligible.
REQ-015 out_ready  in  1  consumer takes head (ignored when AUTO_RETIRE=1).
REQ-016 out_time / out_op  out  TIME_W / 2  head fields.
REQ-017 out_row / out_col / out_bank / out_bank_group / out_burst_order / out_byte_index  out  ADDR_W-18 / 8 / 2 / 2 / 3 / 3  decoded head address.
REQ-018 count  out  clog2(DEPTH+1)  occupied entries.
REQ-019 full / empty  out  1 / 1  count==DEPTH / count==0.
REQ-020 err_illegal_op  out  1  sticky: an op=3 request was presented.

Function
REQ-021 in_ready SHALL equal !full (registered state only; no same-cycle pop bypass).
REQ-022 Push occurs on an edge where in_valid && in_ready && in_op!=3; entry written at tail, tail pointer wraps DEPTH-1 -> 0.
REQ-023 in_valid && in_ready && in_op==3: request consumed, not stored; err_illegal_op set next cycle and held until reset.
REQ-024 Decode at push: byte_index=addr[2:0], burst_order=[5:3], bank_group=[7:6], bank=[9:8], col=[17:10], row=[ADDR_W-1:18].
REQ-025 Each entry carries an age counter: cleared to 0 on push, +1 per cycle, saturating at MIN_AGE.
REQ-026 out_valid = !empty && head age==MIN_AGE; request pushed on edge k gives out_valid from edge k+MIN_AGE (k+0 when MIN_AGE=0, i.e. cycle after push).
REQ-027 Pop occurs on an edge where out_valid && (AUTO_RETIRE || out_ready); head pointer wraps DEPTH-1 -> 0.
REQ-028 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-029 Full: in_valid ignored, no state change from input side; pop in that cycle clears full next cycle.
REQ-030 Empty: out_valid=0, out_ready ignored; count never underflows or overflows.
REQ-031 AUTO_RETIRE=0, out_valid high, out_ready low: head and all out_* fields SHALL stay stable until pop.
REQ-032 count, full, empty, in_ready, out_valid SHALL all be registered or derived from registered state only (no input-to-output combinational path).

Reset
REQ-033 reset high on an edge: head/tail pointers, count, all ages, err_illegal_op -> 0; empty=1, full=0, out_valid=0, in_ready=1 after the edge; stored data need not clear; out_* data fields read 0 while empty.
REQ-034 reset mid-operation discards all entries; push/pop requests in the reset cycle are ignored.

Structure
REQ-035 Shared package ddr4_ctrl_pkg holds the op enum (READ/WRITE/INSTRUCTION_FETCH), the decoded request struct typedef and the address field bit positions.
REQ-036 Storage SHALL be a sub-module mem_req_ring (circular buffer with wrap-around pointers); aging and handshake logic stay in mem_request_queue.

Verification
REQ-037 Defaults, push READ addr 0x0_0004_0305 on edge 0, out_ready=0 -> out_valid rises at edge 100; row=0x1, col=0x00, bank=3, bank_group=0, burst_order=0, byte_index=5.
REQ-038 DEPTH=4, push 5 back-to-back, MIN_AGE=100 -> count=4, full=1, in_ready=0 from edge 4; 5th held until first pop, then accepted.
REQ-039 AUTO_RETIRE=0, MIN_AGE=0, out_ready toggling 1/0 with continuous pushes -> FIFO order preserved across ≥3 pointer wraps, count never >DEPTH.
REQ-040 in_op=3 pushed -> count unchanged, err_illegal_op=1 next cycle, stays 1 until reset.
REQ-041 Assert reset with 3 entries queued -> next cycle count=0, empty=1, out_valid=0, err_illegal_op=0; new push behaves per REQ-037.
